// File: rtl/imem_responder.sv
// Word-addressed instruction memory serving a fetch port in order, with a fixed
// read pipeline, a response FIFO, credit-based request backpressure and a load port.
module imem_responder #(
   parameter int DEPTH_LOG2 = 8,
   parameter int LATENCY    = 2,
   parameter int MAX_OUT    = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [31:0]           req_addr,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [31:0]           rsp_data,
   output logic                  rsp_err,
   input  logic                  load_en,
   input  logic [DEPTH_LOG2-1:0] load_addr,
   input  logic [31:0]           load_data,
   output logic                  busy
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int CNT_W = $clog2(MAX_OUT + 1);
   localparam int PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

   typedef struct packed {
      logic        err;
      logic [31:0] data;
   } rsp_t;

   logic [31:0]           mem [DEPTH];
   logic [LATENCY-1:0]    pipe_vld;
   rsp_t                  pipe_rsp [LATENCY];
   rsp_t                  fifo_mem [MAX_OUT];
   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      rd_ptr;
   logic [CNT_W-1:0]      fifo_cnt;
   logic [CNT_W-1:0]      fifo_cnt_nxt;
   logic [CNT_W-1:0]      out_cnt;
   logic [CNT_W-1:0]      out_cnt_nxt;
   logic                  accept;
   logic                  push;
   logic                  pop;
   logic                  req_err;
   logic [DEPTH_LOG2-1:0] req_idx;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(MAX_OUT - 1)) ? '0 : p + 1'b1;
   endfunction

   // Any upper address bit set is out of range; the low bits are never aliased.
   assign req_err   = |req_addr[31:DEPTH_LOG2];
   assign req_idx   = req_addr[DEPTH_LOG2-1:0];

   // Credits only reflect registered state, so a same-cycle pop never frees a slot.
   assign req_ready = rst & (out_cnt < CNT_W'(MAX_OUT)) & ~load_en;
   assign accept    = req_valid & req_ready;
   assign push      = pipe_vld[LATENCY-1];
   assign rsp_valid = (fifo_cnt != '0);
   assign pop       = rsp_valid & rsp_ready;
   assign busy      = (out_cnt != '0);

   assign rsp_data  = rsp_valid ? fifo_mem[rd_ptr].data : '0;
   assign rsp_err   = rsp_valid ? fifo_mem[rd_ptr].err  : 1'b0;

   always_ff @(posedge clk) begin
      if (load_en)
         mem[load_addr] <= load_data;
   end

   // NOTE: data-only storage (memory, pipeline payload, FIFO entries) has no reset;
   // only the valid bits, pointers and counts that qualify it are cleared.
   always_ff @(posedge clk) begin
      if (accept) begin
         pipe_rsp[0].err  <= req_err;
         pipe_rsp[0].data <= req_err ? '0 : mem[req_idx];
      end
      for (int k = 1; k < LATENCY; k++)
         pipe_rsp[k] <= pipe_rsp[k-1];
   end

   always_ff @(posedge clk) begin
      if (push)
         fifo_mem[wr_ptr] <= pipe_rsp[LATENCY-1];
   end

   always_comb begin
      // NOTE: defaults first so every path assigns and no latch is inferred.
      out_cnt_nxt  = out_cnt;
      fifo_cnt_nxt = fifo_cnt;
      if (accept && !pop)
         out_cnt_nxt = out_cnt + 1'b1;
      else if (!accept && pop)
         out_cnt_nxt = out_cnt - 1'b1;
      if (push && !pop)
         fifo_cnt_nxt = fifo_cnt + 1'b1;
      else if (!push && pop)
         fifo_cnt_nxt = fifo_cnt - 1'b1;
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of process ordering.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pipe_vld <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
         out_cnt  <= '0;
      end else begin
         pipe_vld[0] <= accept;
         for (int k = 1; k < LATENCY; k++)
            pipe_vld[k] <= pipe_vld[k-1];
         if (push)
            wr_ptr <= ptr_inc(wr_ptr);
         if (pop)
            rd_ptr <= ptr_inc(rd_ptr);
         fifo_cnt <= fifo_cnt_nxt;
         out_cnt  <= out_cnt_nxt;
      end
   end

endmodule
